// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data bus between the pipeline (master) and
// the data memory responder (slave). All data paths are 32 bits wide.
interface dmem_responder_if;
    logic [31:0] address;     // byte address
    logic [31:0] write_data;  // store data, right-aligned
    logic [1:0]  byte_sel;    // 00 word, 01 halfword, 10 byte, 11 word
    logic        mem_read;    // load request
    logic        mem_write;   // store request
    logic [31:0] read_data;   // load result, zero-extended, right-aligned
    logic        ready;       // one-cycle completion pulse
    logic        stall;       // request pending and not yet complete
    logic        error;       // one-cycle pulse with ready on a faulted access

    modport master (
        output address, write_data, byte_sel, mem_read, mem_write,
        input  read_data, ready, stall, error
    );

    modport slave (
        input  address, write_data, byte_sel, mem_read, mem_write,
        output read_data, ready, stall, error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data bus.
// Serves loads/stores from an internal 2**ADDR_W x 32 RAM after WAIT_CYCLES
// wait states and completes each request with a one-cycle ready pulse.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word accesses are faulted, and error
//               pulses with ready on every faulted access.
//   undefined - error is tied low; misaligned accesses ignore the offending
//               low address bits; out-of-range and read+write accesses are
//               still suppressed silently.
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2    // 0..15
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready;

    // Request latched at acceptance; only meaningful outside IDLE.
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [1:0]  req_sel_q;
    logic        req_rd_q;
    logic        req_wr_q;
    logic        req_fault_q;

    logic [31:0] read_data_q;
    logic [31:0] mem [2**ADDR_W];

    // Request as seen on the edge into DONE: live inputs when still in IDLE
    // (zero wait states), the latched copy otherwise.
    logic [31:0] cur_addr;
    logic [1:0]  cur_sel;
    logic        cur_rd;
    logic        cur_fault;
    logic        in_fault;
    logic        enter_done;
    logic        commit;
    logic [3:0]  commit_be;
    logic [31:0] commit_data;

    // Faulted access: out of range, read+write, and optionally misaligned.
    function automatic logic fault_of(input logic [31:0] addr, input logic [1:0] sel,
                                      input logic rd, input logic wr);
        logic f;
        f = ((addr >> (ADDR_W + 2)) != 32'd0) || (rd && wr);
`ifdef DMEM_ALIGN_CHECK_EN
        if (sel == SEL_HALF)
            f = f || addr[0];
        else if (sel != SEL_BYTE)
            f = f || (addr[1:0] != 2'b00);
`else
        f = f || (sel == 2'b11 && 1'b0);  // size does not affect faults here
`endif
        return f;
    endfunction

    // Byte-lane enables for a store; misaligned low bits are simply ignored.
    function automatic logic [3:0] lanes_of(input logic [31:0] addr, input logic [1:0] sel);
        case (sel)
            SEL_BYTE: return 4'b0001 << addr[1:0];
            SEL_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it may land in.
    function automatic logic [31:0] place_of(input logic [31:0] wdata, input logic [1:0] sel);
        case (sel)
            SEL_BYTE: return {4{wdata[7:0]}};
            SEL_HALF: return {2{wdata[15:0]}};
            default:  return wdata;
        endcase
    endfunction

    // Pick the addressed byte/halfword out of a RAM word, zero-extended.
    function automatic logic [31:0] extract_of(input logic [31:0] word,
                                               input logic [31:0] addr,
                                               input logic [1:0]  sel);
        case (sel)
            SEL_BYTE: return {24'd0, word[8*addr[1:0] +: 8]};
            SEL_HALF: return {16'd0, addr[1] ? word[31:16] : word[15:0]};
            default:  return word;
        endcase
    endfunction

    assign in_fault  = fault_of(bus.address, bus.byte_sel, bus.mem_read, bus.mem_write);
    assign cur_addr  = (state_q == IDLE) ? bus.address  : req_addr_q;
    assign cur_sel   = (state_q == IDLE) ? bus.byte_sel : req_sel_q;
    assign cur_rd    = (state_q == IDLE) ? bus.mem_read : req_rd_q;
    assign cur_fault = (state_q == IDLE) ? in_fault     : req_fault_q;

    // Next-state, counter and ready pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request when it is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_sel_q   <= 2'b00;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_fault_q <= 1'b0;
        end else if (state_q == IDLE && (bus.mem_read || bus.mem_write)) begin
            req_addr_q  <= bus.address;
            req_wdata_q <= bus.write_data;
            req_sel_q   <= bus.byte_sel;
            req_rd_q    <= bus.mem_read;
            req_wr_q    <= bus.mem_write;
            req_fault_q <= in_fault;
        end
    end

    // Load result is captured on the edge into DONE; faulted loads return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            read_data_q <= 32'd0;
        else if (enter_done && cur_rd)
            read_data_q <= cur_fault ? 32'd0
                         : extract_of(mem[cur_addr[ADDR_W+1:2]], cur_addr, cur_sel);
    end

    // Stores commit on the DONE->IDLE edge; reset in DONE aborts the commit.
    assign commit      = (state_q == DONE) && req_wr_q && !req_fault_q;
    assign commit_be   = lanes_of(req_addr_q, req_sel_q);
    assign commit_data = place_of(req_wdata_q, req_sel_q);

    // RAM write port, one enable per byte lane.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset so it maps onto plain memory;
        // only the control path above is reset.
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (commit_be[i])
                    mem[req_addr_q[ADDR_W+1:2]][8*i +: 8] <= commit_data[8*i +: 8];
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.read_data = read_data_q;
    assign bus.stall     = (bus.mem_read || bus.mem_write) && !ready;
`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.error     = ready && req_fault_q;
`else
    assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed tests for dmem_responder (ADDR_W=10,
// WAIT_CYCLES=2). Expected values are hand-computed constants; error
// expectations follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int W      = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge. Drives one request, waits (bounded)
    // for ready, and returns just after the following rising edge. With
    // hold=1 the request stays asserted so the next call continues directly.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] sel, input logic hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic stall_ok);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.address    = addr;
        bus.write_data = wdata;
        bus.byte_sel   = sel;
        lat      = -1;
        rdata    = 32'd0;
        err      = 1'b0;
        stall_ok = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat   = n;
                rdata = bus.read_data;
                err   = bus.error;
                if (bus.stall) stall_ok = 1'b0;
                break;
            end
            if (!bus.stall) stall_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        sok;
    int          rdy_cnt;

    initial begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;
        bus.byte_sel   = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Prior contents of 0x10, then a store aborted by reset mid-WAIT
        access(1, 0, 32'h0, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        access(0, 1, 32'h10, 32'h0BADF00D, 2'b00, 0, rdata, err, lat, sok);
        check("w10_lat", 32'(lat), 32'(W + 1));
        bus.mem_write  = 1'b1;
        bus.address    = 32'h10;
        bus.write_data = 32'hDEADBEEF;
        bus.byte_sel   = 2'b00;
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.mem_write = 1'b0;
        rdy_cnt       = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ready) rdy_cnt++;
        end
        check("abort_ready", 32'(rdy_cnt), 32'd0);
        check("abort_rdata", bus.read_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1, 0, 32'h10, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("abort_keep", rdata, 32'h0BADF00D);

        // Word write / read with latency and stall shape
        access(0, 1, 32'h20, 32'h12345678, 2'b00, 0, rdata, err, lat, sok);
        check("w20_lat", 32'(lat), 32'(W + 1));
        check("w20_stall", 32'(sok), 32'd1);
        check("w20_err", 32'(err), 32'd0);
        access(1, 0, 32'h20, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("r20_data", rdata, 32'h12345678);
        check("r20_lat", 32'(lat), 32'(W + 1));

        // Sub-word stores; stores leave read_data untouched
        access(0, 1, 32'h21, 32'h000000AB, 2'b10, 0, rdata, err, lat, sok);
        access(0, 1, 32'h22, 32'h0000CDEF, 2'b01, 0, rdata, err, lat, sok);
        @(negedge clk);
        check("rd_hold", bus.read_data, 32'h12345678);
        @(posedge clk);
        #1;
        access(1, 0, 32'h20, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("r20_merged", rdata, 32'hCDEFAB78);
        access(1, 0, 32'h23, 32'h0, 2'b10, 0, rdata, err, lat, sok);
        check("r23_byte", rdata, 32'h000000CD);
        access(1, 0, 32'h20, 32'h0, 2'b01, 0, rdata, err, lat, sok);
        check("r20_half", rdata, 32'h0000AB78);

        // Back-to-back reads with the request held
        access(0, 1, 32'h24, 32'h55AA1234, 2'b00, 0, rdata, err, lat, sok);
        access(1, 0, 32'h20, 32'h0, 2'b00, 1, rdata, err, lat, sok);
        check("b2b_first", rdata, 32'hCDEFAB78);
        access(1, 0, 32'h24, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("b2b_second", rdata, 32'h55AA1234);
        check("b2b_gap", 32'(lat), 32'(W + 1));
        check("b2b_stall", 32'(sok), 32'd1);

        // Out of range
        access(1, 0, 32'h00100000, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("oor_rdata", rdata, 32'd0);
        check("oor_err", 32'(err), 32'(ERR_EN));
        access(0, 1, 32'h00100020, 32'hFFFFFFFF, 2'b00, 0, rdata, err, lat, sok);
        check("oorw_err", 32'(err), 32'(ERR_EN));
        access(1, 0, 32'h20, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("oorw_keep", rdata, 32'hCDEFAB78);

        // Simultaneous read and write
        access(1, 1, 32'h20, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("rw_err", 32'(err), 32'(ERR_EN));
        check("rw_lat", 32'(lat), 32'(W + 1));
        access(1, 0, 32'h20, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("rw_keep", rdata, 32'hCDEFAB78);

        // Misaligned halfword store
        access(0, 1, 32'h30, 32'hA5A5A5A5, 2'b00, 0, rdata, err, lat, sok);
        access(0, 1, 32'h31, 32'h00001111, 2'b01, 0, rdata, err, lat, sok);
        check("mis_err", 32'(err), 32'(ERR_EN));
        access(1, 0, 32'h30, 32'h0, 2'b00, 0, rdata, err, lat, sok);
        check("mis_word", rdata, ERR_EN ? 32'hA5A5A5A5 : 32'hA5A51111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
